mult_err_monitor: RTL and testbench

Streaming error-metric accumulator that sits directly downstream of an 8x8 approximate multiplier under test. Each accepted sample carries the two operands and the approximate 16-bit product; the block recomputes the exact product and accumulates sample count, error count, summed error distance and maximum error distance over a programmed number of samples. It then holds the results for readout. This replaces offline post-processing of dumped products with an on-chip measurement of approximation quality.

---
 rtl/mult_err_monitor_pkg.sv | 39 +++
 rtl/mult_err_monitor_if.sv | 31 +++
 rtl/mult_err_monitor_stage.sv | 76 +++++++
 rtl/mult_err_monitor.sv | 167 ++++++++++++++++
 tb/tb_mult_err_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_err_monitor_pkg.sv
// Shared types, default widths and the saturating accumulate helper
// for the approximate-multiplier error monitor.
package mult_err_pkg;

    localparam int unsigned OP_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF = 20;
    localparam int unsigned SUM_W_DEF = 40;

    // Widest accumulator sat_add can handle.
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Adds inc to acc and clamps at the all-ones value of a width-bit
    // accumulator. Operands are carried at 64 bits so one function
    // serves every accumulator width up to SAT_MAX_W.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        if (width >= SAT_MAX_W) begin
            lim = {1'b0, {64{1'b1}}};
        end else begin
            lim = (65'd1 << width) - 65'd1;
        end
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/mult_err_monitor_if.sv
// Sample stream from the multiplier under test into the monitor:
// operands, approximate product and a valid/ready handshake.
interface mult_err_monitor_if
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W = OP_W_DEF
) ();

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in0;
    logic [OP_W-1:0]     in1;
    logic [2*OP_W-1:0]   approx;

    modport master (
        output in_valid,
        output in0,
        output in1,
        output approx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in0,
        input  in1,
        input  approx,
        output in_ready
    );

endinterface

// File: rtl/mult_err_monitor_stage.sv
// Two-stage error-distance datapath: S1 registers the exact product and
// the approximate product, S2 registers |exact - approx|.
module mult_err_stage
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W = OP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept_i,
    input  logic [OP_W-1:0]     in0_i,
    input  logic [OP_W-1:0]     in1_i,
    input  logic [2*OP_W-1:0]   approx_i,
    output logic                s1_valid_o,
    output logic                ed_valid_o,
    output logic [2*OP_W-1:0]   ed_o
);

    localparam int unsigned P_W = 2 * OP_W;

    logic             s1_valid_q;
    logic [P_W-1:0]   exact_q;
    logic [P_W-1:0]   approx_q;

    logic signed [P_W:0] diff;
    logic        [P_W:0] mag;
    logic [P_W-1:0]      ed_d;

    logic             ed_valid_q;
    logic [P_W-1:0]   ed_q;

    // S1: capture the exact product and the multiplier's result per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            exact_q    <= '0;
            approx_q   <= '0;
        end else begin
            s1_valid_q <= accept_i;
            if (accept_i) begin
                exact_q  <= P_W'(in0_i) * P_W'(in1_i);
                approx_q <= approx_i;
            end
        end
    end

    // Error distance: one-bit-wider signed difference, then magnitude.
    always_comb begin
        diff = $signed({1'b0, exact_q}) - $signed({1'b0, approx_q});
        mag  = '0;
        if (diff[P_W]) begin
            mag = -diff;
        end else begin
            mag = diff;
        end
        ed_d = mag[P_W-1:0];
    end

    // S2: register the error distance for the accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_valid_q <= 1'b0;
            ed_q       <= '0;
        end else begin
            ed_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                ed_q <= ed_d;
            end
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign ed_valid_o = ed_valid_q;
    assign ed_o       = ed_q;

endmodule

// File: rtl/mult_err_monitor.sv
// Streaming error-metric accumulator for an approximate multiplier:
// counts samples and nonzero errors, sums and maxes the error distance
// over a programmed run length, then holds the results with done high.
module mult_err_monitor
    import mult_err_pkg::*;
#(
    parameter int unsigned OP_W  = OP_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned SUM_W = SUM_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     num_samples_i,
    mult_err_monitor_if.slave    s_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     sample_cnt_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [SUM_W-1:0]     err_sum_o,
    output logic [2*OP_W-1:0]    err_max_o
);

    localparam int unsigned P_W = 2 * OP_W;

    state_e            state_q;
    logic [CNT_W-1:0]  target_q;
    logic [CNT_W-1:0]  acc_cnt_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              start_ok;
    logic              last_accept;

    logic              s1_valid;
    logic              ed_valid;
    logic [P_W-1:0]    ed;

    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;
    logic [SUM_W-1:0]  err_sum_q,    err_sum_d;
    logic [P_W-1:0]    err_max_q,    err_max_d;

    assign accept      = s_if.in_valid && in_ready_q;
    assign start_ok    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_accept = (acc_cnt_q + CNT_W'(1)) == target_q;

    assign s_if.in_ready = in_ready_q;

    mult_err_stage #(
        .OP_W (OP_W)
    ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .in0_i      (s_if.in0),
        .in1_i      (s_if.in1),
        .approx_i   (s_if.approx),
        .s1_valid_o (s1_valid),
        .ed_valid_o (ed_valid),
        .ed_o       (ed)
    );

    // Run control FSM; in_ready/busy/done are registered from the next state.
    // DRAIN exits once S1 is empty: the last sample then sits in S2 and is
    // folded into the results on the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            acc_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        target_q  <= num_samples_i;
                        acc_cnt_q <= '0;
                        if (num_samples_i == '0) begin
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                        if (last_accept) begin
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Next result values: cleared by an accepted start, else fold in S2.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sum_d    = err_sum_q;
        err_max_d    = err_max_q;
        if (start_ok) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            err_sum_d    = '0;
            err_max_d    = '0;
        end else if (ed_valid) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (ed != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            err_sum_d = SUM_W'(sat_add(64'(err_sum_q), 64'(ed), SUM_W));
            if (ed > err_max_q) begin
                err_max_d = ed;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sum_q    <= err_sum_d;
            err_max_q    <= err_max_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_sum_o    = err_sum_q;
    assign err_max_o    = err_max_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Self-checking bench for mult_err_monitor: a run-level reference model
// checked against the DUT every cycle, plus hand-computed result checks.
module tb_mult_err_monitor;

    localparam int unsigned CW  = 20;
    localparam int unsigned SW  = 40;
    localparam int unsigned SWB = 17;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT A (default widths) ----------------
    logic            start_a;
    logic [CW-1:0]   num_a;
    logic            busy_a, done_a;
    logic [CW-1:0]   scnt_a, ecnt_a;
    logic [SW-1:0]   esum_a;
    logic [15:0]     emax_a;

    mult_err_monitor_if #(.OP_W(8)) if_a ();

    mult_err_monitor #(.OP_W(8), .CNT_W(CW), .SUM_W(SW)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_a),
        .num_samples_i (num_a),
        .s_if          (if_a),
        .busy_o        (busy_a),
        .done_o        (done_a),
        .sample_cnt_o  (scnt_a),
        .err_cnt_o     (ecnt_a),
        .err_sum_o     (esum_a),
        .err_max_o     (emax_a)
    );

    // ---------------- DUT B (narrow sum for saturation) ----------------
    logic            start_b;
    logic [CW-1:0]   num_b;
    logic            busy_b, done_b;
    logic [CW-1:0]   scnt_b, ecnt_b;
    logic [SWB-1:0]  esum_b;
    logic [15:0]     emax_b;

    mult_err_monitor_if #(.OP_W(8)) if_b ();

    mult_err_monitor #(.OP_W(8), .CNT_W(CW), .SUM_W(SWB)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_b),
        .num_samples_i (num_b),
        .s_if          (if_b),
        .busy_o        (busy_b),
        .done_o        (done_b),
        .sample_cnt_o  (scnt_b),
        .err_cnt_o     (ecnt_b),
        .err_sum_o     (esum_b),
        .err_max_o     (emax_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for DUT A ----------------
    // Run bookkeeping: accepting while m_run, then a two-cycle drain
    // before results are declared final. Per-sample error distances ride
    // a two-entry delay line so each one lands two edges after acceptance.
    bit              m_run, m_done;
    int unsigned     m_drain, m_acc, m_tgt;
    longint unsigned m_cnt, m_errc, m_sum, m_max;
    bit              pv0, pv1;
    int unsigned     ped0, ped1;
    longint unsigned sum_lim_a = (64'd1 << SW) - 64'd1;

    always @(posedge clk or negedge rst_n) begin : model
        bit          acc_now, av;
        int unsigned ex, ap, ed_now, aed;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_drain = 0; m_acc = 0; m_tgt = 0;
            m_cnt = 0; m_errc = 0; m_sum = 0; m_max = 0;
            pv0 = 0; pv1 = 0; ped0 = 0; ped1 = 0;
        end else begin
            acc_now = if_a.in_valid && m_run;
            ex      = if_a.in0 * if_a.in1;
            ap      = if_a.approx;
            ed_now  = (ex >= ap) ? ex - ap : ap - ex;
            av  = pv1;  aed  = ped1;
            pv1 = pv0;  ped1 = ped0;
            pv0 = acc_now; ped0 = ed_now;
            if (start_a && !m_run && m_drain == 0) begin
                m_cnt = 0; m_errc = 0; m_sum = 0; m_max = 0;
                m_tgt = num_a; m_acc = 0;
                if (num_a == 0) begin
                    m_done = 1;
                end else begin
                    m_run = 1; m_done = 0;
                end
            end else begin
                if (av) begin
                    m_cnt++;
                    if (aed != 0) m_errc++;
                    m_sum = (m_sum + aed > sum_lim_a) ? sum_lim_a : m_sum + aed;
                    if (aed > m_max) m_max = aed;
                end
                if (acc_now) begin
                    m_acc++;
                    if (m_acc == m_tgt) begin
                        m_run = 0; m_drain = 2;
                    end
                end else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_done = 1;
                end
            end
        end
    end

    int rdy_cycles = 0;

    // Per-cycle compare of DUT A against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",   if_a.in_ready, m_run);
        chk("busy",       busy_a, m_run || (m_drain != 0));
        chk("done",       done_a, m_done);
        chk("sample_cnt", scnt_a, m_cnt);
        chk("err_cnt",    ecnt_a, m_errc);
        chk("err_sum",    esum_a, m_sum);
        chk("err_max",    emax_a, m_max);
        if (if_a.in_ready) rdy_cycles++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run_a(input int unsigned n);
        start_a = 1'b1;
        num_a   = CW'(n);
        tick();
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        bit took = 0;
        int n = 0;
        if_a.in_valid = 1'b1;
        if_a.in0 = a; if_a.in1 = b; if_a.approx = p;
        while (!took && n < 200) begin
            took = if_a.in_ready;
            tick();
            n++;
        end
        if (!took) begin
            n_checks++; n_fail++;
            $display("FAIL send_a timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic send_b(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        bit took = 0;
        int n = 0;
        if_b.in_valid = 1'b1;
        if_b.in0 = a; if_b.in1 = b; if_b.approx = p;
        while (!took && n < 200) begin
            took = if_b.in_ready;
            tick();
            n++;
        end
        if (!took) begin
            n_checks++; n_fail++;
            $display("FAIL send_b timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 50) begin
            tick();
            n++;
        end
        chk("done_a_within_bound", done_a, 1);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!done_b && n < 50) begin
            tick();
            n++;
        end
        chk("done_b_within_bound", done_b, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        start_a = 0; num_a = '0;
        if_a.in_valid = 0; if_a.in0 = '0; if_a.in1 = '0; if_a.approx = '0;
        start_b = 0; num_b = '0;
        if_b.in_valid = 0; if_b.in0 = '0; if_b.in1 = '0; if_b.approx = '0;

        #2 rst_n = 1'b0;
        tick();
        chk("reset in_ready", if_a.in_ready, 0);
        chk("reset busy",     busy_a, 0);
        chk("reset done",     done_a, 0);
        chk("reset sum",      esum_a, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single exact sample; start arrives together with in_valid.
        if_a.in_valid = 1; if_a.in0 = 8'd3; if_a.in1 = 8'd5; if_a.approx = 16'd15;
        start_run_a(1);
        send_a(8'd3, 8'd5, 16'd15);
        if_a.in_valid = 0;
        chk("t1 done +0", done_a, 0);
        tick();
        chk("t1 done +1", done_a, 0);
        tick();
        chk("t1 done +2", done_a, 1);
        chk("t1 sample_cnt", scnt_a, 1);
        chk("t1 err_cnt",    ecnt_a, 0);
        chk("t1 err_sum",    esum_a, 0);
        chk("t1 err_max",    emax_a, 0);

        // Three samples with errors 5, 5, 65025.
        start_run_a(3);
        send_a(8'd3,   8'd5,   16'd20);
        send_a(8'd3,   8'd5,   16'd10);
        send_a(8'd255, 8'd255, 16'd0);
        if_a.in_valid = 0;
        wait_done_a();
        chk("t2 sample_cnt", scnt_a, 3);
        chk("t2 err_cnt",    ecnt_a, 3);
        chk("t2 err_sum",    esum_a, 65035);
        chk("t2 err_max",    emax_a, 65025);
        chk("t2 model sum",  m_sum,  65035);

        // 1000 back-to-back exact samples.
        rdy_cycles = 0;
        start_run_a(1000);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'(i);
            b = ~8'(i);
            send_a(a, b, 16'(a) * 16'(b));
        end
        if_a.in_valid = 0;
        wait_done_a();
        chk("t3 ready cycles", rdy_cycles, 1000);
        chk("t3 sample_cnt",   scnt_a, 1000);
        chk("t3 err_cnt",      ecnt_a, 0);

        // Ten samples with random gaps and ignored start pulses.
        start_run_a(10);
        for (int i = 0; i < 10; i++) begin
            int unsigned g;
            logic [7:0] a;
            g = $urandom_range(0, 2);
            if (g != 0) begin
                if_a.in_valid = 0;
                start_a = 1; num_a = CW'(7);
                tick();
                start_a = 0;
                for (int j = 1; j < int'(g); j++) tick();
            end
            a = 8'(i + 1);
            send_a(a, 8'd2, 16'(a) * 16'd2 + 16'(i % 2));
        end
        if_a.in_valid = 0;
        wait_done_a();
        chk("t4 sample_cnt", scnt_a, 10);
        chk("t4 err_cnt",    ecnt_a, 5);
        chk("t4 err_sum",    esum_a, 5);
        chk("t4 err_max",    emax_a, 1);
        chk("t4 model errc", m_errc, 5);

        // Reset in the middle of a run.
        start_run_a(5);
        send_a(8'd10, 8'd10, 16'd50);
        send_a(8'd20, 8'd20, 16'd100);
        if_a.in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst in_ready",   if_a.in_ready, 0);
        chk("t5 rst busy",       busy_a, 0);
        chk("t5 rst done",       done_a, 0);
        chk("t5 rst sample_cnt", scnt_a, 0);
        chk("t5 rst err_sum",    esum_a, 0);
        chk("t5 rst err_max",    emax_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5 idle after rst", busy_a | done_a, 0);

        // Zero-length run: done on the next cycle with cleared results.
        start_run_a(0);
        chk("t6 done",       done_a, 1);
        chk("t6 busy",       busy_a, 0);
        chk("t6 sample_cnt", scnt_a, 0);
        chk("t6 err_sum",    esum_a, 0);

        // Fresh two-sample run after reset: errors 10 and 0.
        start_run_a(2);
        send_a(8'd10,  8'd10, 16'd90);
        send_a(8'd200, 8'd3,  16'd600);
        if_a.in_valid = 0;
        wait_done_a();
        chk("t7 sample_cnt", scnt_a, 2);
        chk("t7 err_cnt",    ecnt_a, 1);
        chk("t7 err_sum",    esum_a, 10);
        chk("t7 err_max",    emax_a, 10);

        // Saturation of a 17-bit sum: 3 x 65025 clamps to 131071.
        start_b = 1; num_b = CW'(3);
        tick();
        start_b = 0;
        for (int i = 0; i < 3; i++) send_b(8'd255, 8'd255, 16'd0);
        if_b.in_valid = 0;
        wait_done_b();
        chk("t8 sat err_sum",    esum_b, 131071);
        chk("t8 sat err_cnt",    ecnt_b, 3);
        chk("t8 sat err_max",    emax_b, 65025);
        chk("t8 sat sample_cnt", scnt_b, 3);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
